// File: rtl/shift_left_unit.sv
// Logical left-shift unit: combinational barrel shifter with lost-bit detection plus a registered stage.
// Optional feature: define SHIFT_LEFT_SAT_EN to saturate the result to all ones when bits are lost.
module shift_left_unit #(
    parameter int WIDTH = 32,
    parameter int SHAMT = 2,
    parameter int SHW   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in,
    input  logic             dyn_en,
    input  logic [SHW-1:0]   dyn_shamt,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             lost,
    output logic [WIDTH-1:0] out_q,
    output logic             lost_q,
    output logic             out_valid
);

    localparam int NSTG = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // WIDTH always fits in SHW+1 bits because 2**SHW >= WIDTH
    localparam logic [SHW:0] WLIM = (SHW + 1)'(WIDTH);

    logic [SHW-1:0]   amount;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] mask;
    logic             lost_raw;
    logic             over;

    always_comb begin
        amount   = dyn_en ? dyn_shamt : SHW'(SHAMT);
        shifted  = in;
        mask     = '0;
        lost_raw = 1'b0;
        over     = ({1'b0, amount} >= WLIM);
        // Each stage drops its top 2**k bits; the union across stages is the top 'amount' bits of in
        for (int unsigned k = 0; k < NSTG; k++) begin
            if (amount[k]) begin
                mask     = ~({WIDTH{1'b1}} >> (1 << k));
                lost_raw = lost_raw | (|(shifted & mask));
                shifted  = shifted << (1 << k);
            end
        end
        if (over) begin
            shifted  = '0;
            lost_raw = |in;
        end
    end

    assign lost = lost_raw;

`ifdef SHIFT_LEFT_SAT_EN
    assign out = lost_raw ? '1 : shifted;
`else
    assign out = shifted;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q     <= '0;
            lost_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_q  <= out;
                lost_q <= lost;
            end
        end
    end

endmodule

// File: tb/tb_shift_left_unit.sv
// Directed self-checking bench for shift_left_unit (default parameters).
// Honours SHIFT_LEFT_SAT_EN when computing expected values.
module tb_shift_left_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] in;
    logic        dyn_en;
    logic [4:0]  dyn_shamt;
    logic        in_valid;
    logic [31:0] out;
    logic        lost;
    logic [31:0] out_q;
    logic        lost_q;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    shift_left_unit #(.WIDTH(32), .SHAMT(2), .SHW(5)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .in(in),
        .dyn_en(dyn_en),
        .dyn_shamt(dyn_shamt),
        .in_valid(in_valid),
        .out(out),
        .lost(lost),
        .out_q(out_q),
        .lost_q(lost_q),
        .out_valid(out_valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    localparam logic [31:0] C_LOST_OUT =
`ifdef SHIFT_LEFT_SAT_EN
        32'hFFFF_FFFF;
`else
        32'h0000_0004;
`endif

    localparam logic [31:0] C_SH16_OUT =
`ifdef SHIFT_LEFT_SAT_EN
        32'hFFFF_FFFF;
`else
        32'h8000_0000;
`endif

    initial begin
        Reset     = 1'b1;
        in        = '0;
        dyn_en    = 1'b0;
        dyn_shamt = '0;
        in_valid  = 1'b0;
        tick();
        tick();
        check("rst_out_q", out_q, 32'h0);
        check("rst_lost_q", {31'b0, lost_q}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);

        // Combinational path, fixed shift of 2 (Reset still high: must not matter)
        in = 32'd1;  #50;
        check("fix_in1_out", out, 32'd4);
        check("fix_in1_lost", {31'b0, lost}, 32'h0);
        in = 32'd8;  #50;
        check("fix_in8_out", out, 32'd32);
        check("fix_in8_lost", {31'b0, lost}, 32'h0);
        in = 32'd54; #50;
        check("fix_in54_out", out, 32'd216);
        check("fix_in54_lost", {31'b0, lost}, 32'h0);
        in = 32'hC000_0001; #10;
        check("fix_lost_out", out, C_LOST_OUT);
        check("fix_lost_lost", {31'b0, lost}, 32'h1);

        // Dynamic shift amounts
        dyn_en = 1'b1;
        dyn_shamt = 5'd31; in = 32'd1; #10;
        check("dyn31_out", out, 32'h8000_0000);
        check("dyn31_lost", {31'b0, lost}, 32'h0);
        dyn_shamt = 5'd0; in = 32'hDEAD_BEEF; #10;
        check("dyn0_out", out, 32'hDEAD_BEEF);
        check("dyn0_lost", {31'b0, lost}, 32'h0);
        dyn_shamt = 5'd16; in = 32'h0001_8000; #10;
        check("dyn16_out", out, C_SH16_OUT);
        check("dyn16_lost", {31'b0, lost}, 32'h1);
        dyn_shamt = 5'd4; in = 32'h0800_0003; #10;
        check("dyn4_out", out, 32'h8000_0030);
        check("dyn4_lost", {31'b0, lost}, 32'h0);

        // Pipeline, fixed shift, back-to-back valid
        dyn_en = 1'b0;
        Reset  = 1'b0;
        in = 32'd1; in_valid = 1'b1;
        tick();
        check("pipe1_out_q", out_q, 32'd4);
        check("pipe1_valid", {31'b0, out_valid}, 32'h1);
        in = 32'd8;
        tick();
        check("pipe2_out_q", out_q, 32'd32);
        check("pipe2_valid", {31'b0, out_valid}, 32'h1);
        in = 32'd54;
        tick();
        check("pipe3_out_q", out_q, 32'd216);
        check("pipe3_valid", {31'b0, out_valid}, 32'h1);
        check("pipe3_lost_q", {31'b0, lost_q}, 32'h0);

        // Idle: registered value holds, combinational keeps tracking
        in_valid = 1'b0; in = 32'd3;
        tick();
        check("hold_out_q", out_q, 32'd216);
        check("hold_valid", {31'b0, out_valid}, 32'h0);
        check("hold_comb_out", out, 32'd12);

        in_valid = 1'b1; in = 32'hC000_0001;
        tick();
        check("plost_out_q", out_q, C_LOST_OUT);
        check("plost_lost_q", {31'b0, lost_q}, 32'h1);

        // Mid-stream reset drops the pending operand
        in = 32'd8; Reset = 1'b1;
        tick();
        check("mrst_out_q", out_q, 32'h0);
        check("mrst_lost_q", {31'b0, lost_q}, 32'h0);
        check("mrst_valid", {31'b0, out_valid}, 32'h0);
        check("mrst_comb_out", out, 32'd32);

        Reset = 1'b0; in = 32'd54;
        tick();
        check("resume_out_q", out_q, 32'd216);
        check("resume_valid", {31'b0, out_valid}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
